// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID-stage hazard controller state encoding.
package mips_pkg;

  localparam int unsigned OPW = 6;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_BNE   = 6'h05;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SB    = 6'h28;
  localparam logic [OPW-1:0] OP_SH    = 6'h29;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;
  localparam logic [OPW-1:0] OP_HALT  = 6'h3F;

  localparam logic [OPW-1:0] FN_JR    = 6'h08;
  localparam logic [OPW-1:0] FN_JALR  = 6'h09;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL2 = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Stores read rt as the data operand.
  function automatic logic is_store(input logic [OPW-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-on-load hazard flags for the instruction in ID.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int unsigned SIZE_REG_DIR = 5,
  parameter int unsigned SIZE_OP      = 6
) (
  input  logic [SIZE_OP-1:0]      op,
  input  logic [SIZE_OP-1:0]      funct,
  input  logic [SIZE_REG_DIR-1:0] rs,
  input  logic [SIZE_REG_DIR-1:0] rt,
  input  logic                    mem_read_id_ex,
  input  logic [SIZE_REG_DIR-1:0] rd_id_ex,
  input  logic                    mem_read_ex_mem,
  input  logic [SIZE_REG_DIR-1:0] rd_ex_mem,
  output logic                    lu_c,
  output logic                    bl1_c,
  output logic                    bl2_c
);

  logic [OPW-1:0] op6;
  logic [OPW-1:0] fn6;
  logic           is_rtype;
  logic           uses_rt;
  logic           is_br;
  logic           match_id_ex;
  logic           match_ex_mem;

  assign op6      = OPW'(op);
  assign fn6      = OPW'(funct);
  assign is_rtype = (op6 == OP_RTYPE);
  assign uses_rt  = is_rtype || is_store(op6) || (op6 == OP_BEQ) || (op6 == OP_BNE);
  assign is_br    = (op6 == OP_BEQ) || (op6 == OP_BNE) ||
                    (is_rtype && ((fn6 == FN_JR) || (fn6 == FN_JALR)));

  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign match_id_ex  = (rd_id_ex != '0) &&
                        ((rd_id_ex == rs) || (uses_rt && (rd_id_ex == rt)));
  assign match_ex_mem = (rd_ex_mem != '0) &&
                        ((rd_ex_mem == rs) || (uses_rt && (rd_ex_mem == rt)));

  assign lu_c  = mem_read_id_ex && match_id_ex;
  assign bl2_c = is_br && lu_c;
  assign bl1_c = is_br && mem_read_ex_mem && match_ex_mem;

endmodule

// File: rtl/id_hazard_controller.sv
// ID-stage sequencer: hazard stalls, bubbles, branch/jump flushes, debug run/step gate and halt.
module id_hazard_controller
  import mips_pkg::*;
#(
  parameter int unsigned SIZE_REG_DIR = 5,
  parameter int unsigned SIZE_OP      = 6,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIZE_OP-1:0]      i_op_id,
  input  logic [SIZE_OP-1:0]      i_funct_id,
  input  logic [SIZE_REG_DIR-1:0] i_rs_id,
  input  logic [SIZE_REG_DIR-1:0] i_rt_id,
  input  logic                    i_mem_read_id_ex,
  input  logic [SIZE_REG_DIR-1:0] i_rd_id_ex,
  input  logic                    i_mem_read_ex_mem,
  input  logic [SIZE_REG_DIR-1:0] i_rd_ex_mem,
  input  logic                    i_branch_taken,
  input  logic                    i_jump_id,
  input  logic                    i_halt_wb,
  input  logic                    i_dbg_mode,
  input  logic                    i_dbg_step,
  output logic                    o_pipe_en,
  output logic                    o_stall_pc,
  output logic                    o_stall_if_id,
  output logic                    o_bubble_id_ex,
  output logic                    o_flush_if_id,
  output logic                    o_halted,
  output logic [CNT_W-1:0]        o_stall_cycles
);

  state_e           state_q;
  state_e           state_d;
  logic             step_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lu;
  logic             bl1;
  logic             bl2;
  logic             step_rise;
  logic             pipe_en_c;
  logic             stall_c;
  logic             flush_c;
  logic             halted_c;

  hazard_detect #(
    .SIZE_REG_DIR (SIZE_REG_DIR),
    .SIZE_OP      (SIZE_OP)
  ) u_hazard_detect (
    .op              (i_op_id),
    .funct           (i_funct_id),
    .rs              (i_rs_id),
    .rt              (i_rt_id),
    .mem_read_id_ex  (i_mem_read_id_ex),
    .rd_id_ex        (i_rd_id_ex),
    .mem_read_ex_mem (i_mem_read_ex_mem),
    .rd_ex_mem       (i_rd_ex_mem),
    .lu_c            (lu),
    .bl1_c           (bl1),
    .bl2_c           (bl2)
  );

  assign step_rise = i_dbg_step & ~step_q;

  // Next state and same-cycle strobes; a disabled cycle freezes the FSM and silences strobes.
  always_comb begin
    state_d   = state_q;
    pipe_en_c = 1'b0;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    halted_c  = 1'b0;
    if (rst) begin
      if (state_q == ST_HALTED) begin
        halted_c = 1'b1;
      end else begin
        pipe_en_c = i_dbg_mode ? step_rise : 1'b1;
        if (pipe_en_c) begin
          case (state_q)
            ST_STALL2: begin
              stall_c = 1'b1;
              state_d = ST_RUN;
            end
            default: begin
              if (bl2) begin
                stall_c = 1'b1;
                state_d = ST_STALL2;
              end else if (lu || bl1) begin
                stall_c = 1'b1;
              end
            end
          endcase
          flush_c = (i_branch_taken | i_jump_id) & ~stall_c;
        end
        if (i_halt_wb) state_d = ST_HALTED;
      end
    end
  end

  // State, step-edge history and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= i_dbg_step;
      if (pipe_en_c && stall_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_pipe_en      = pipe_en_c;
  assign o_stall_pc     = stall_c;
  assign o_stall_if_id  = stall_c;
  assign o_bubble_id_ex = stall_c;
  assign o_flush_if_id  = flush_c;
  assign o_halted       = halted_c;
  assign o_stall_cycles = rst ? cnt_q : '0;

endmodule
